// File: rtl/lifo_stack_p.sv
// Parametrised LIFO with registered top-of-stack peek, a popped-data register,
// full/empty/count status and sticky overflow/underflow flags.
module lifo_stack_p #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 64,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_valid,
    output logic [DATA_WIDTH-1:0] top,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] top_q, top_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  q_valid_q, q_valid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  wr_en;
    logic [PTR_WIDTH-1:0]  wr_idx;
    logic [CNT_WIDTH-1:0]  cnt_m1, cnt_m2;
    logic                  new_ovf, new_udf;

    assign cnt_m1 = count_q - CNT_WIDTH'(1);
    assign cnt_m2 = count_q - CNT_WIDTH'(2);

    always_comb begin
        count_d   = count_q;
        top_d     = top_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        new_ovf   = 1'b0;
        new_udf   = 1'b0;

        unique case ({push, pop})
            2'b10: begin
                if (!full_q) begin
                    wr_en   = 1'b1;
                    wr_idx  = count_q[PTR_WIDTH-1:0];
                    count_d = count_q + CNT_WIDTH'(1);
                    top_d   = d;
                end else begin
                    new_ovf = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_q) begin
                    q_d       = top_q;
                    q_valid_d = 1'b1;
                    count_d   = cnt_m1;
                    // The entry below the current top becomes the new peek value.
                    top_d     = (count_q >= CNT_WIDTH'(2)) ? mem_q[cnt_m2[PTR_WIDTH-1:0]] : '0;
                end else begin
                    new_udf = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_q) begin
                    q_d       = top_q;
                    q_valid_d = 1'b1;
                    wr_en     = 1'b1;
                    wr_idx    = cnt_m1[PTR_WIDTH-1:0];
                    top_d     = d;
                end else begin
                    // Empty stack: the pushed word goes straight out, nothing is stored.
                    q_d       = d;
                    q_valid_d = 1'b1;
                end
            end
            default: ;
        endcase

        full_d  = (count_d == CNT_WIDTH'(DEPTH));
        empty_d = (count_d == '0);
        ovf_d   = (ovf_q & ~err_clr) | new_ovf;
        udf_d   = (udf_q & ~err_clr) | new_udf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            top_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            top_q     <= top_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage is deliberately not reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_idx] <= d;
        end
    end

    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign top       = top_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule
